// File: rtl/regfile_pkg.sv
// Shared constants and write-port arbitration for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Returns {we1_eff, we0_eff}.
  // Port 1 shadows port 0 on an address clash, and the zero register swallows writes.
  function automatic logic [1:0] eff_we(
    input logic we0,
    input logic we1,
    input logic same_addr,
    input logic wa0_zero,
    input logic wa1_zero,
    input logic zero_reg
  );
    logic e0;
    logic e1;
    e1 = we1 & ~(zero_reg & wa1_zero);
    e0 = we0 & ~(we1 & same_addr) & ~(zero_reg & wa0_zero);
    return {e1, e0};
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: forwards in-flight write data and hides busy
// for a register that is being written this cycle.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] word,
  input  logic              busy_bit,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd,
  output logic              rbusy
);

  logic is_zero;
  logic hit0;
  logic hit1;

  assign is_zero = (ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR));
  assign hit1    = (BYPASS != 0) && we1 && (wa1 == ra);
  assign hit0    = (BYPASS != 0) && we0 && (wa0 == ra);

  // Zero register wins over forwarding; port 1 wins over port 0.
  always_comb begin
    rd = word;
    if (is_zero)   rd = '0;
    else if (hit1) rd = wd1;
    else if (hit0) rd = wd0;
  end

  always_comb begin
    rbusy = busy_bit;
    if (is_zero || hit0 || hit1) rbusy = 1'b0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, optional bypass,
// hardwired zero register, busy scoreboard and a registered debug port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   ra,
  output logic [N_RD*DATA_W-1:0]   rd,
  output logic [N_RD-1:0]          rbusy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     bset,
  input  logic [ADDR_W-1:0]        bset_a,
  input  logic [ADDR_W-1:0]        dbg_a,
  output logic [DATA_W-1:0]        dbg_d
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [1:0]        we_eff;
  logic              zero_en;

  assign zero_en = (ZERO_REG != 0);

  always_comb begin
    we_eff = eff_we(we0, we1, wa0 == wa1,
                    wa0 == ADDR_W'(ZERO_ADDR), wa1 == ADDR_W'(ZERO_ADDR), zero_en);
  end

  // Clears first so a same-edge bset re-marks the register for its new producer.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (bset && !(zero_en && bset_a == ADDR_W'(ZERO_ADDR))) busy_nxt[bset_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy  <= '0;
      dbg_d <= '0;
    end else begin
      dbg_d <= mem[dbg_a];
      if (we_eff[0]) mem[wa0] <= wd0;
      if (we_eff[1]) mem[wa1] <= wd1;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    assign ra_i = ra[i*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rp (
      .ra      (ra_i),
      .word    (mem[ra_i]),
      .busy_bit(busy[ra_i]),
      .we0     (we0),
      .wa0     (wa0),
      .wd0     (wd0),
      .we1     (we1),
      .wa1     (wa1),
      .wd1     (wd1),
      .rd      (rd[i*DATA_W +: DATA_W]),
      .rbusy   (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed cases from the test plan followed by
// random traffic, checked against a plain array model of the register file.
module tb_regfile_mp;

  typedef struct {
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic        we0, we1, bset;
    logic [4:0]  wa0, wa1, bset_a, dbg_a;
    logic [31:0] wd0, wd1;
  } stim_t;

  typedef struct {
    logic [31:0] rd0, rd1, dbg;
    logic [1:0]  rbusy;
  } exp_t;

  logic        clk = 1'b0;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [31:0] dbg_d;
  stim_t       cur;
  exp_t        exp_q[$];

  logic [31:0] mmem [32];
  bit          mbusy [32];
  logic [31:0] mdbg;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign ra = {cur.ra1, cur.ra0};

  regfile_mp dut (
    .clk   (clk),
    .rst   (cur.rst),
    .ra    (ra),
    .rd    (rd),
    .rbusy (rbusy),
    .we0   (cur.we0),
    .wa0   (cur.wa0),
    .wd0   (cur.wd0),
    .we1   (cur.we1),
    .wa1   (cur.wa1),
    .wd1   (cur.wd1),
    .bset  (cur.bset),
    .bset_a(cur.bset_a),
    .dbg_a (cur.dbg_a),
    .dbg_d (dbg_d)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a read of address a returns this cycle.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (cur.we1 && cur.wa1 == a) return cur.wd1;
    if (cur.we0 && cur.wa0 == a) return cur.wd0;
    return mmem[a];
  endfunction

  function automatic logic modelBusy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((cur.we1 && cur.wa1 == a) || (cur.we0 && cur.wa0 == a)) return 1'b0;
    return mbusy[a];
  endfunction

  // Applies the current inputs to the model as one clock edge.
  task automatic modelEdge();
    if (cur.rst) begin
      for (int i = 0; i < 32; i++) begin mmem[i] = 32'h0; mbusy[i] = 0; end
      mdbg = 32'h0;
    end else begin
      mdbg = mmem[cur.dbg_a];
      if (cur.we0 && cur.wa0 != 0) mmem[cur.wa0] = cur.wd0;
      if (cur.we1 && cur.wa1 != 0) mmem[cur.wa1] = cur.wd1;
      if (cur.we0) mbusy[cur.wa0] = 0;
      if (cur.we1) mbusy[cur.wa1] = 0;
      if (cur.bset && cur.bset_a != 0) mbusy[cur.bset_a] = 1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    modelEdge();
    #1;
    cur = s;
    e.rd0   = modelRead(s.ra0);
    e.rd1   = modelRead(s.ra1);
    e.rbusy = {modelBusy(s.ra1), modelBusy(s.ra0)};
    e.dbg   = mdbg;
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle(input logic [4:0] r0, input logic [4:0] r1);
    stim_t s;
    s = '{rst: 1'b0, ra0: r0, ra1: r1, we0: 1'b0, we1: 1'b0, bset: 1'b0,
          wa0: 5'd0, wa1: 5'd0, bset_a: 5'd0, dbg_a: 5'd0, wd0: 32'h0, wd1: 32'h0};
    return s;
  endfunction

  // Monitor: every cycle the DUT outputs are settled, compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("rd0",   rd[31:0],  e.rd0);
      checkOutput("rd1",   rd[63:32], e.rd1);
      checkOutput("rbusy", {30'h0, rbusy}, {30'h0, e.rbusy});
      checkOutput("dbg_d", dbg_d, e.dbg);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    cur = idle(5'd0, 5'd0);
    cur.rst = 1'b1;

    s = idle(5'd3, 5'd5); s.rst = 1'b1; applyStimulus(s);
    s = idle(5'd3, 5'd5); s.dbg_a = 5'd3; applyStimulus(s);
    s = idle(5'd3, 5'd0); s.we0 = 1; s.wa0 = 5'd3; s.wd0 = 32'h3; applyStimulus(s);
    s = idle(5'd3, 5'd0); applyStimulus(s);
    s = idle(5'd5, 5'd3); s.we0 = 1; s.wa0 = 5'd5; s.wd0 = 32'hAA;
    s.we1 = 1; s.wa1 = 5'd5; s.wd1 = 32'h55; applyStimulus(s);
    s = idle(5'd5, 5'd0); s.dbg_a = 5'd5; applyStimulus(s);
    s = idle(5'd0, 5'd5); s.we0 = 1; s.wa0 = 5'd0; s.wd0 = 32'hFFFF_FFFF;
    s.bset = 1; s.bset_a = 5'd0; applyStimulus(s);
    s = idle(5'd0, 5'd5); s.dbg_a = 5'd0; applyStimulus(s);
    s = idle(5'd7, 5'd0); s.bset = 1; s.bset_a = 5'd7; applyStimulus(s);
    s = idle(5'd7, 5'd0); applyStimulus(s);
    s = idle(5'd7, 5'd7); s.we1 = 1; s.wa1 = 5'd7; s.wd1 = 32'h7; applyStimulus(s);
    s = idle(5'd7, 5'd0); applyStimulus(s);
    s = idle(5'd7, 5'd7); s.bset = 1; s.bset_a = 5'd7;
    s.we0 = 1; s.wa0 = 5'd7; s.wd0 = 32'h9; applyStimulus(s);
    s = idle(5'd7, 5'd0); applyStimulus(s);
    s = idle(5'd4, 5'd7); s.dbg_a = 5'd4; s.we0 = 1; s.wa0 = 5'd4; s.wd0 = 32'h4; applyStimulus(s);
    s = idle(5'd4, 5'd7); s.dbg_a = 5'd4; applyStimulus(s);
    s = idle(5'd4, 5'd7); s.dbg_a = 5'd4; applyStimulus(s);
    s = idle(5'd4, 5'd7); s.dbg_a = 5'd4; s.rst = 1'b1; applyStimulus(s);
    s = idle(5'd4, 5'd7); s.dbg_a = 5'd4; applyStimulus(s);

    for (int n = 0; n < 400; n++) begin
      s.rst    = ($urandom_range(0, 63) == 0);
      s.ra0    = 5'($urandom_range(0, 31));
      s.ra1    = 5'($urandom_range(0, 31));
      s.we0    = 1'($urandom_range(0, 1));
      s.we1    = 1'($urandom_range(0, 1));
      s.bset   = ($urandom_range(0, 2) == 0);
      // Narrow address range makes clashes between ports and reads common.
      s.wa0    = 5'($urandom_range(0, 7));
      s.wa1    = 5'($urandom_range(0, 7));
      s.bset_a = 5'($urandom_range(0, 7));
      s.dbg_a  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin s.ra0 = s.wa0; s.ra1 = s.wa1; end
      s.wd0    = $urandom;
      s.wd1    = $urandom;
      applyStimulus(s);
    end

    s = idle(5'd1, 5'd2); applyStimulus(s);
    @(negedge clk);
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined CPU datapath. It generalises the two-read, one-write register file with:
- configurable data width, depth and read-port count;
- two write ports with fixed priority;
- optional write-to-read bypass and a hardwired zero register;
- a per-register busy scoreboard for hazard detection;
- a registered debug read port.

It sits between the decode stage (reads, busy queries) and the writeback stage (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, if 1, register 0 reads 0 and ignores writes and busy sets
- BYPASS, 1, if 1, same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  N_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd  out  N_RD*DATA_W  read data, combinational; port i at [i*DATA_W +: DATA_W]
- rbusy  out  N_RD  busy flag for the register addressed by port i
- we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write port 0
- we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write port 1, priority over port 0
- bset  in  1  mark register bset_a busy (producer issued)
- bset_a  in  ADDR_W  register to mark busy
- dbg_a  in  ADDR_W  debug read address
- dbg_d  out  DATA_W  debug read data, registered

## Operation
- Reset (clk edge with rst=1):
  - all registers, all busy bits and dbg_d go to 0;
  - writes and bset in that cycle are ignored;
  - reset mid-operation discards all state; the first post-reset edge behaves as from power-up.
- Write: on the edge, if we1, reg[wa1] <= wd1. If we0 and (!we1 or wa0 != wa1), reg[wa0] <= wd0.
  - Equal addresses with both enabled: port 1 wins, and port 0 has no effect on that register.
- Zero register (ZERO_REG=1):
  - writes to address 0 are dropped;
  - rd for address 0 is always 0, even when bypassing;
  - bset to address 0 is ignored and busy[0] stays 0.
- Read: rd[i] = reg[ra[i]], with bypass applied first when BYPASS=1:
  - if we1 and wa1 == ra[i], rd[i] = wd1;
  - else if we0 and wa0 == ra[i], rd[i] = wd0.
  - Zero-register rule overrides bypass.
- Scoreboard:
  - busy[a] is set on an edge with bset and bset_a == a;
  - busy[a] is cleared on an edge with any enabled write to a;
  - set and clear of the same address on the same edge: set wins (new producer).
- rbusy[i] = busy[ra[i]], masked to 0 when BYPASS=1 and an enabled write targets ra[i] in the current cycle.
- Debug: dbg_d <= reg[dbg_a] on each edge. This is the array value before that edge's write; no bypass.

## Timing
- rd, rbusy: combinational, 0-cycle latency from ra, writes and busy state.
- Write visible in the array one edge after it is presented. It is visible in the same cycle via bypass only when BYPASS=1.
- With BYPASS=0, a read of an address being written in the same cycle returns the old value.
- dbg_d: 1-cycle latency. A write at edge k is seen at dbg_d after edge k+1.
- Busy set at edge k: rbusy asserts immediately after edge k, until the edge of the clearing write.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W constants, ZERO_ADDR constant, and a function computing the effective write enable per port (priority plus zero masking).
- Sub-module rf_read_port: one per read port, generated N_RD times. It takes the array word and both write ports, and outputs bypassed rd and masked rbusy.
- Array and busy vector stay in the top module.

## Test plan
- Reset then read all addresses with rst=1 held one edge: every rd = 0, rbusy = 0, and the next cycle dbg_d = 0.
- Write 0x3 to r3 via port 0, then read r3 next cycle: rd = 0x3. With BYPASS=1, the same-cycle read of r3 already returns 0x3; with BYPASS=0 it returns 0.
- Same edge: we0 r5 = 0xAA and we1 r5 = 0x55. Result: r5 = 0x55. Bypassed read of r5 that cycle also returns 0x55.
- Write 0xFFFF_FFFF to r0 and bset r0: rd for r0 stays 0 and rbusy stays 0.
- bset r7 at edge 1: rbusy = 1.
  - Write r7 = 0x7 at edge 3: rbusy is 0 from edge 3 (combinationally 0 during the write cycle with BYPASS=1).
  - Simultaneous bset r7 and write r7: r7 = new data and busy stays 1.
- Write r4 = 0x4 at edge k with dbg_a = 4: dbg_d = old value after edge k and 0x4 after edge k+1. Assert rst mid-sequence: dbg_d and all rd return 0 after the next edge.
